// File: rtl/led_pattern_sequencer_if.sv
// Switch inputs and LED/status outputs of the LED pattern sequencer.
// The slave modport is the sequencer; the master modport is the board or bench side.
interface led_pattern_sequencer_if;
    logic       sw_mode_i;
    logic       sw_pause_i;
    logic       LED_1_o;
    logic       LED_2_o;
    logic       LED_3_o;
    logic       LED_4_o;
    logic [1:0] mode_o;
    logic       paused_o;
    logic       tick_o;

    modport master (
        output sw_mode_i, sw_pause_i,
        input  LED_1_o, LED_2_o, LED_3_o, LED_4_o, mode_o, paused_o, tick_o
    );

    modport slave (
        input  sw_mode_i, sw_pause_i,
        output LED_1_o, LED_2_o, LED_3_o, LED_4_o, mode_o, paused_o, tick_o
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// 4-LED pattern sequencer: debounced mode/pause switches, IDLE/RING/BOUNCE/BLINK modes,
// patterns stepped on an internal tick enable.
module led_pattern_sequencer #(
    parameter int TICK_DIV     = 25_000_000,
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    led_pattern_sequencer_if.slave io
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    // Index 0 is the mode switch, index 1 the pause switch.
    logic [1:0]         raw;
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d;
    logic [1:0]         press_q, press_d;
    logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    mode_e         mode_q, mode_d;
    logic [3:0]    pattern_q, pattern_d;
    logic          dir_up_q, dir_up_d;
    logic          paused_q, paused_d;
    logic          tick_q, tick_d;
    logic          step_fire;

    assign raw = {io.sw_pause_i, io.sw_mode_i};

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        deb_d    = deb_q;
        press_d  = '0;
        db_cnt_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]   = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // A mode press takes priority over a step that fires in the same cycle.
    always_comb begin
        step_fire  = !paused_q && (tick_cnt_q == TICK_LAST);
        mode_d     = mode_q;
        pattern_d  = pattern_q;
        dir_up_d   = dir_up_q;
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        paused_d   = paused_q ^ press_q[1];

        if (press_q[0]) begin
            tick_cnt_d = '0;
            case (mode_q)
                IDLE:   begin mode_d = RING;   pattern_d = 4'b0001; end
                RING:   begin mode_d = BOUNCE; pattern_d = 4'b0001; dir_up_d = 1'b1; end
                BOUNCE: begin mode_d = BLINK;  pattern_d = 4'b1111; end
                BLINK:  begin mode_d = IDLE;   pattern_d = 4'b0000; end
            endcase
        end else if (step_fire) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
            case (mode_q)
                IDLE: pattern_d = 4'b0000;
                RING: pattern_d = {pattern_q[2:0], pattern_q[3]};
                BOUNCE: begin
                    if (dir_up_q) begin
                        if (pattern_q[3]) begin
                            pattern_d = pattern_q >> 1;
                            dir_up_d  = 1'b0;
                        end else begin
                            pattern_d = pattern_q << 1;
                        end
                    end else begin
                        if (pattern_q[0]) begin
                            pattern_d = pattern_q << 1;
                            dir_up_d  = 1'b1;
                        end else begin
                            pattern_d = pattern_q >> 1;
                        end
                    end
                end
                BLINK: pattern_d = ~pattern_q;
            endcase
        end else if (!paused_q) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            press_q    <= '0;
            db_cnt_q   <= '0;
            tick_cnt_q <= '0;
            mode_q     <= IDLE;
            pattern_q  <= '0;
            dir_up_q   <= 1'b0;
            paused_q   <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            press_q    <= press_d;
            db_cnt_q   <= db_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            dir_up_q   <= dir_up_d;
            paused_q   <= paused_d;
            tick_q     <= tick_d;
        end
    end

    assign io.LED_1_o  = pattern_q[0];
    assign io.LED_2_o  = pattern_q[1];
    assign io.LED_3_o  = pattern_q[2];
    assign io.LED_4_o  = pattern_q[3];
    assign io.mode_o   = mode_q;
    assign io.paused_o = paused_q;
    assign io.tick_o   = tick_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: hand-computed vector table, randomized switch activity
// against a step-index reference model, and an asynchronous reset between clock edges.
module tb_led_pattern_sequencer;
    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_pattern_sequencer_if io ();

    led_pattern_sequencer #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYC(DEB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .io    (io)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode number, steps taken since mode entry, and cycles since last step.
    int m_mode, m_idx, m_phase;
    bit m_paused, m_tick;
    bit m_pend[2];
    bit m_deb[2];
    bit m_hist[2][DEB+2];

    typedef struct {
        bit         m;
        bit         p;
        int         n;
        logic [3:0] led;
        logic [1:0] mode;
        bit         paused;
        bit         tick;
    } vec_t;

    vec_t tbl[26];

    function automatic logic [3:0] exp_led(input int mode, input int idx);
        case (mode)
            1: return 4'(1 << (idx % 4));
            2: case (idx % 6)
                   0: return 4'b0001;
                   1: return 4'b0010;
                   2: return 4'b0100;
                   3: return 4'b1000;
                   4: return 4'b0100;
                   default: return 4'b0010;
               endcase
            3: return (idx % 2 == 0) ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [7:0] dut_out();
        return {io.LED_4_o, io.LED_3_o, io.LED_2_o, io.LED_1_o, io.mode_o, io.paused_o, io.tick_o};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_phase = 0;
        m_paused = 1'b0; m_tick = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0;
            m_deb[i]  = 1'b0;
            for (int j = 0; j < DEB + 2; j++) m_hist[i][j] = 1'b0;
        end
    endtask

    // One clock edge: presses accepted last edge take effect now; a level is accepted once
    // the last DEB synchronised samples (raw delayed by two edges) all differ from it.
    task automatic model_step(input bit m, input bit p);
        bit fire, acc;
        bit raw[2];
        raw[0] = m;
        raw[1] = p;
        fire   = !m_paused && (m_phase == TICK_DIV - 1);
        m_tick = 1'b0;
        if (m_pend[0]) begin
            m_mode  = (m_mode + 1) % 4;
            m_idx   = 0;
            m_phase = 0;
        end else if (fire) begin
            m_idx++;
            m_phase = 0;
            m_tick  = 1'b1;
        end else if (!m_paused) begin
            m_phase++;
        end
        if (m_pend[1]) m_paused = !m_paused;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < DEB + 1; j++) m_hist[i][j] = m_hist[i][j+1];
            m_hist[i][DEB+1] = raw[i];
            acc = 1'b1;
            for (int j = 0; j < DEB; j++) if (m_hist[i][j] == m_deb[i]) acc = 1'b0;
            m_pend[i] = 1'b0;
            if (acc) begin
                m_deb[i]  = !m_deb[i];
                m_pend[i] = m_deb[i];
            end
        end
    endtask

    task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got led=%b mode=%0d paused=%b tick=%b, expected led=%b mode=%0d paused=%b tick=%b",
                     name, $time, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic clk_cycle(input bit m, input bit p, input string name);
        io.sw_mode_i  = m;
        io.sw_pause_i = p;
        @(posedge clk);
        model_step(m, p);
        #1;
        compare(name, dut_out(), {exp_led(m_mode, m_idx), 2'(m_mode), m_paused, m_tick});
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        io.sw_mode_i  = 1'b0;
        io.sw_pause_i = 1'b0;
        model_reset();
        #1;
        compare("reset_state", dut_out(), 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // {mode sw, pause sw, cycles held, then LEDs, mode, paused, tick after the last edge}
        tbl[0]  = '{0, 0, 20, 4'b0000, 2'd0, 0, 1};
        tbl[1]  = '{1, 0,  6, 4'b0001, 2'd1, 0, 0};
        tbl[2]  = '{1, 0,  4, 4'b0010, 2'd1, 0, 1};
        tbl[3]  = '{0, 0,  4, 4'b0100, 2'd1, 0, 1};
        tbl[4]  = '{1, 0,  2, 4'b0100, 2'd1, 0, 0};
        tbl[5]  = '{0, 0,  2, 4'b1000, 2'd1, 0, 1};
        tbl[6]  = '{0, 0,  4, 4'b0001, 2'd1, 0, 1};
        tbl[7]  = '{0, 0,  5, 4'b0010, 2'd1, 0, 0};
        tbl[8]  = '{0, 1,  6, 4'b0100, 2'd1, 1, 0};
        tbl[9]  = '{0, 1, 40, 4'b0100, 2'd1, 1, 0};
        tbl[10] = '{0, 0, 10, 4'b0100, 2'd1, 1, 0};
        tbl[11] = '{0, 1,  6, 4'b0100, 2'd1, 0, 0};
        tbl[12] = '{0, 1,  1, 4'b1000, 2'd1, 0, 1};
        tbl[13] = '{0, 0,  4, 4'b0001, 2'd1, 0, 1};
        tbl[14] = '{1, 0,  6, 4'b0001, 2'd2, 0, 0};
        tbl[15] = '{0, 0,  4, 4'b0010, 2'd2, 0, 1};
        tbl[16] = '{0, 0, 12, 4'b0100, 2'd2, 0, 1};
        tbl[17] = '{0, 0, 16, 4'b0100, 2'd2, 0, 1};
        tbl[18] = '{1, 0,  6, 4'b1111, 2'd3, 0, 0};
        tbl[19] = '{0, 0,  4, 4'b0000, 2'd3, 0, 1};
        tbl[20] = '{0, 0,  4, 4'b1111, 2'd3, 0, 1};
        tbl[21] = '{0, 0,  2, 4'b1111, 2'd3, 0, 0};
        tbl[22] = '{1, 0,  6, 4'b0000, 2'd0, 0, 0};
        tbl[23] = '{0, 0,  6, 4'b0000, 2'd0, 0, 0};
        tbl[24] = '{1, 1,  6, 4'b0001, 2'd1, 1, 0};
        tbl[25] = '{0, 0,  8, 4'b0001, 2'd1, 1, 0};

        do_reset();
        for (int v = 0; v < 26; v++) begin
            repeat (tbl[v].n) clk_cycle(tbl[v].m, tbl[v].p, "model_table");
            compare($sformatf("vec%0d", v), dut_out(),
                    {tbl[v].led, tbl[v].mode, tbl[v].paused, tbl[v].tick});
        end

        // Random switch activity with run lengths around the debounce window.
        for (int c = 0; c < 2000; ) begin
            int run;
            bit rm, rp;
            run = int'($urandom_range(1, 8));
            rm  = 1'($urandom_range(0, 1));
            rp  = ($urandom_range(0, 3) == 0);
            repeat (run) clk_cycle(rm, rp, "model_random");
            c += run;
        end

        // Reach BOUNCE, then assert reset between clock edges.
        do_reset();
        repeat (6)  clk_cycle(1'b1, 1'b0, "model_pre_rst");
        repeat (6)  clk_cycle(1'b0, 1'b0, "model_pre_rst");
        repeat (6)  clk_cycle(1'b1, 1'b0, "model_pre_rst");
        repeat (10) clk_cycle(1'b0, 1'b0, "model_pre_rst");
        compare("pre_rst_mode", {6'b0, io.mode_o}, 8'h02);
        #3;
        rst = 1'b1;
        #1;
        compare("async_rst", dut_out(), 8'h00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) clk_cycle(1'b0, 1'b0, "model_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
